// File: rtl/adc_channel_sequencer.sv
// ---------------------------------------------------------------------------
// adc_channel_sequencer
//
// Walks the external ADC mux through the enabled channels of a scan. For each
// enabled channel it drives the mux address, fires a one-cycle start-of-
// conversion pulse, then waits for a rising edge on the ADC's conversion-done
// line before moving on to the next enabled channel. It runs either a single
// scan or repeats the scan continuously.
//
// Optional feature (macro ADC_SETTLE_EN):
//   When defined, each start of conversion is preceded by SETTLE_CYCLES
//   cycles of mux settle time. When undefined, there is no settle state and
//   conversions start straight away.
//
// Parameters:
//   NUM_CH        number of mux channels (2..2**ADDR_W)
//   ADDR_W        width of the mux address
//   SETTLE_CYCLES settle wait before each conversion (ADC_SETTLE_EN only)
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   init         scan request, looked at only while idle
//   continuous   1 = restart the scan after the last enabled channel
//   ch_mask      per-channel enable, bit i enables channel i
//   OE_R         raw conversion-done level from the ADC
//   add_o        mux address / channel being converted
//   soc_o        start-of-conversion pulse
//   ch_valid_o   pulse: conversion on add_o is complete
//   scan_done_o  pulse: last enabled channel of the scan is complete
//   busy_o       high whenever a scan is in progress
// ---------------------------------------------------------------------------
module adc_channel_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int ADDR_W        = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              OE_R,
    output logic [ADDR_W-1:0] add_o,
    output logic              soc_o,
    output logic              ch_valid_o,
    output logic              scan_done_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef ADC_SETTLE_EN
        ST_SETTLE,
`endif
        ST_START,
        ST_WAIT,
        ST_ADVANCE
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] mask_reg;
    logic              oe_hist;
    logic              oe_edge;

    logic [ADDR_W-1:0] first_ch;
    logic [ADDR_W-1:0] next_ch;
    logic              next_found;
    logic              mask_nonzero;
    logic              launch;
    state_t            launch_state;
    logic              launch_soc;

    // The history register powers up (and resets) high so that an ADC that
    // is already holding its done line high is not mistaken for an edge.
    assign oe_edge      = OE_R & ~oe_hist;
    assign mask_nonzero = |ch_mask;

    // Lowest enabled channel of the live mask, used whenever a scan is
    // (re)started and the mask is latched.
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = ADDR_W'(i);
            end
        end
    end

    // Nearest enabled channel strictly above the current one in the latched
    // mask. Scanning downwards leaves the smallest qualifying index last.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_reg[i] && (i > int'(add_o))) begin
                next_ch    = ADDR_W'(i);
                next_found = 1'b1;
            end
        end
    end

    // A launch is any move into the settle/start path: a fresh scan from
    // idle, a step to the next channel, or a continuous-mode wrap.
    always_comb begin
        launch = 1'b0;
        if ((state == ST_IDLE) && init && mask_nonzero) begin
            launch = 1'b1;
        end else if ((state == ST_ADVANCE) &&
                     (next_found || (continuous && mask_nonzero))) begin
            launch = 1'b1;
        end
    end

`ifdef ADC_SETTLE_EN
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    logic [CNT_W-1:0] settle_cnt;

    // A zero settle time skips the settle state entirely.
    assign launch_state = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_START;

    // Settle counter reloads on every launch so each channel gets the full
    // settle time, then counts down while in SETTLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_cnt <= '0;
        end else if (launch) begin
            settle_cnt <= CNT_W'(SETTLE_CYCLES);
        end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end
`else
    logic unused_settle;

    assign launch_state  = ST_START;
    assign unused_settle = (SETTLE_CYCLES != 0);
`endif

    assign launch_soc = (launch_state == ST_START);

    // Main sequencer. Outputs are registered alongside the state so each one
    // is high exactly for the cycles the matching state is held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            add_o       <= '0;
            soc_o       <= 1'b0;
            ch_valid_o  <= 1'b0;
            scan_done_o <= 1'b0;
            busy_o      <= 1'b0;
            mask_reg    <= '0;
            oe_hist     <= 1'b1;
        end else begin
            oe_hist     <= OE_R;
            soc_o       <= 1'b0;
            ch_valid_o  <= 1'b0;
            scan_done_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        mask_reg <= ch_mask;
                        add_o    <= first_ch;
                        state    <= launch_state;
                        soc_o    <= launch_soc;
                        busy_o   <= 1'b1;
                    end
                end

`ifdef ADC_SETTLE_EN
                ST_SETTLE: begin
                    if (settle_cnt <= CNT_W'(1)) begin
                        state <= ST_START;
                        soc_o <= 1'b1;
                    end
                end
`endif

                ST_START: begin
                    state <= ST_WAIT;
                end

                // add_o is stable here, so the end-of-scan decision can be
                // made now and presented together with ch_valid_o.
                ST_WAIT: begin
                    if (oe_edge) begin
                        state       <= ST_ADVANCE;
                        ch_valid_o  <= 1'b1;
                        scan_done_o <= ~next_found;
                    end
                end

                ST_ADVANCE: begin
                    if (next_found) begin
                        add_o <= next_ch;
                        state <= launch_state;
                        soc_o <= launch_soc;
                    end else if (continuous) begin
                        mask_reg <= ch_mask;
                        if (mask_nonzero) begin
                            add_o <= first_ch;
                            state <= launch_state;
                            soc_o <= launch_soc;
                        end else begin
                            add_o  <= '0;
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        add_o  <= '0;
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    add_o  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_channel_sequencer
//
// Directed test bench for adc_channel_sequencer. Each scenario task drives
// the sequencer and compares the outputs against hand-derived expectations.
// Expected soc_o latency follows the settle feature when ADC_SETTLE_EN is
// defined for the build.
// ---------------------------------------------------------------------------
module tb_adc_channel_sequencer;

    localparam int NUM_CH        = 8;
    localparam int ADDR_W        = 3;
    localparam int SETTLE_CYCLES = 4;
`ifdef ADC_SETTLE_EN
    localparam int SET_LAT = SETTLE_CYCLES;
`else
    localparam int SET_LAT = 0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              init = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              OE_R = 1'b0;
    logic [ADDR_W-1:0] add_o;
    logic              soc_o;
    logic              ch_valid_o;
    logic              scan_done_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    int soc_cnt   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;

    adc_channel_sequencer #(
        .NUM_CH       (NUM_CH),
        .ADDR_W       (ADDR_W),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .init       (init),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .OE_R       (OE_R),
        .add_o      (add_o),
        .soc_o      (soc_o),
        .ch_valid_o (ch_valid_o),
        .scan_done_o(scan_done_o),
        .busy_o     (busy_o)
    );

    always #5 CLK = ~CLK;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (soc_o === 1'b1)       soc_cnt++;
        if (ch_valid_o === 1'b1)  valid_cnt++;
        if (scan_done_o === 1'b1) done_cnt++;
    end

    // Advance one clock and settle just after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Pulse init for one edge; returns in the first cycle after it.
    task automatic pulse_init();
        init = 1'b1;
        step(1);
        init = 1'b0;
    endtask

    // Entered in the cycle soc_o is expected for channel ch. Checks the
    // start, gives the done edge 3 cycles later, and checks completion.
    // Returns in the ADVANCE cycle.
    task automatic do_channel(input int ch, input bit last, input bit poke_init);
        checks++;
        if (soc_o !== 1'b1 || add_o !== ADDR_W'(ch) || busy_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ch%0d: soc_o=%b add_o=%0d busy_o=%b, want soc_o=1 add_o=%0d busy_o=1",
                     ch, soc_o, add_o, busy_o, ch);
        end
        if (poke_init) init = 1'b1;
        step(1);
        init = 1'b0;
        step(2);
        OE_R = 1'b1;
        step(1);
        OE_R = 1'b0;
        checks++;
        if (ch_valid_o !== 1'b1 || add_o !== ADDR_W'(ch) || scan_done_o !== last || soc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_ch%0d: ch_valid_o=%b add_o=%0d scan_done_o=%b soc_o=%b, want 1 %0d %b 0",
                     ch, ch_valid_o, add_o, scan_done_o, soc_o, ch, last);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        OE_R = 1'b1;
        step(3);
        RST = 1'b0;
        checks++;
        if (add_o !== '0 || soc_o !== 1'b0 || ch_valid_o !== 1'b0 ||
            scan_done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: add_o=%0d soc=%b valid=%b done=%b busy=%b, want all 0",
                     add_o, soc_o, ch_valid_o, scan_done_o, busy_o);
        end
        step(3);
        OE_R = 1'b0;
        step(2);
        checks++;
        if (busy_o !== 1'b0 || valid_cnt != 0) begin
            failures++;
            $display("[TB] FAIL reset_idle: busy_o=%b valid_cnt=%0d, want 0 0", busy_o, valid_cnt);
        end
    endtask

    task automatic test_full_scan();
        int s0, v0, d0;
        s0 = soc_cnt; v0 = valid_cnt; d0 = done_cnt;
        ch_mask = 8'hFF;
        continuous = 1'b0;
        pulse_init();
        step(SET_LAT);
        for (int ch = 0; ch < 8; ch++) begin
            do_channel(ch, ch == 7, 1'b0);
            if (ch != 7) step(1 + SET_LAT);
        end
        step(1);
        checks++;
        if (add_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_idle: add_o=%0d busy_o=%b, want 0 0", add_o, busy_o);
        end
        checks++;
        if (soc_cnt - s0 != 8 || valid_cnt - v0 != 8 || done_cnt - d0 != 1) begin
            failures++;
            $display("[TB] FAIL full_counts: soc=%0d valid=%0d done=%0d, want 8 8 1",
                     soc_cnt - s0, valid_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_sparse_mask();
        int s0;
        int exp_ch[3] = '{2, 5, 7};
        s0 = soc_cnt;
        ch_mask = 8'b1010_0100;
        pulse_init();
        step(SET_LAT);
        for (int k = 0; k < 3; k++) begin
            do_channel(exp_ch[k], k == 2, 1'b0);
            if (k != 2) step(1 + SET_LAT);
        end
        step(1);
        checks++;
        if (soc_cnt - s0 != 3 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sparse_end: soc=%0d busy_o=%b, want 3 0", soc_cnt - s0, busy_o);
        end
    endtask

    task automatic test_continuous();
        int d0;
        d0 = done_cnt;
        ch_mask = 8'h03;
        continuous = 1'b1;
        pulse_init();
        step(SET_LAT);
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 2) continuous = 1'b0;
            do_channel(0, 1'b0, 1'b0);
            step(1 + SET_LAT);
            do_channel(1, 1'b1, 1'b0);
            if (pass != 2) step(1 + SET_LAT);
        end
        step(1);
        checks++;
        if (busy_o !== 1'b0 || add_o !== '0 || done_cnt - d0 != 3) begin
            failures++;
            $display("[TB] FAIL cont_stop: busy_o=%b add_o=%0d done=%0d, want 0 0 3",
                     busy_o, add_o, done_cnt - d0);
        end
        step(4);
        checks++;
        if (soc_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cont_quiet: soc_o=%b busy_o=%b, want 0 0", soc_o, busy_o);
        end
    endtask

    task automatic test_corner_cases();
        int s0, v0;
        // Empty mask: init is ignored.
        s0 = soc_cnt;
        ch_mask = '0;
        pulse_init();
        step(SET_LAT + 4);
        checks++;
        if (busy_o !== 1'b0 || soc_cnt != s0) begin
            failures++;
            $display("[TB] FAIL empty_mask: busy_o=%b soc=%0d, want 0 0", busy_o, soc_cnt - s0);
        end

        // init while busy, plus a mid-scan mask change: neither alters
        // the running scan and nothing is queued afterwards.
        s0 = soc_cnt;
        ch_mask = 8'h06;
        pulse_init();
        ch_mask = 8'h01;
        step(SET_LAT);
        do_channel(1, 1'b0, 1'b1);
        step(1 + SET_LAT);
        do_channel(2, 1'b1, 1'b0);
        step(SET_LAT + 5);
        checks++;
        if (busy_o !== 1'b0 || soc_cnt - s0 != 2) begin
            failures++;
            $display("[TB] FAIL busy_init: busy_o=%b soc=%0d, want 0 2", busy_o, soc_cnt - s0);
        end

        // Done line already high through the start: no completion until
        // it falls and rises again.
        v0 = valid_cnt;
        ch_mask = 8'h10;
        OE_R = 1'b1;
        pulse_init();
        step(SET_LAT + 6);
        checks++;
        if (valid_cnt != v0 || busy_o !== 1'b1 || add_o !== 3'd4) begin
            failures++;
            $display("[TB] FAIL oe_high: valid=%0d busy_o=%b add_o=%0d, want 0 1 4",
                     valid_cnt - v0, busy_o, add_o);
        end
        OE_R = 1'b0;
        step(1);
        OE_R = 1'b1;
        step(1);
        checks++;
        if (ch_valid_o !== 1'b1 || scan_done_o !== 1'b1 || add_o !== 3'd4) begin
            failures++;
            $display("[TB] FAIL oe_rise: valid=%b done=%b add_o=%0d, want 1 1 4",
                     ch_valid_o, scan_done_o, add_o);
        end
        OE_R = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid_scan();
        int v0, s0;
        ch_mask = 8'h18;
        pulse_init();
        step(SET_LAT);
        checks++;
        if (soc_o !== 1'b1 || add_o !== 3'd3) begin
            failures++;
            $display("[TB] FAIL rst_setup: soc_o=%b add_o=%0d, want 1 3", soc_o, add_o);
        end
        step(2);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        checks++;
        if (add_o !== '0 || busy_o !== 1'b0 || soc_o !== 1'b0 ||
            ch_valid_o !== 1'b0 || scan_done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid: add_o=%0d busy=%b soc=%b valid=%b done=%b, want all 0",
                     add_o, busy_o, soc_o, ch_valid_o, scan_done_o);
        end
        v0 = valid_cnt;
        s0 = soc_cnt;
        step(1);
        OE_R = 1'b1;
        step(1);
        OE_R = 1'b0;
        step(3);
        checks++;
        if (valid_cnt != v0 || soc_cnt != s0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_after: valid=%0d soc=%0d busy=%b, want 0 0 0",
                     valid_cnt - v0, soc_cnt - s0, busy_o);
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_continuous();
        test_corner_cases();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
